// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the IMEM loader: FSM states and stream framing widths.
package imem_loader_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = BYTES_PER_WORD * BYTE_W;
  localparam int unsigned LEN_W          = 16;
  localparam int unsigned CNT_W          = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    LEN_LO = 3'd0,
    LEN_HI = 3'd1,
    DATA   = 3'd2,
    CSUM   = 3'd3,
    DONE   = 3'd4,
    ERROR  = 3'd5
  } state_e;

endpackage

// File: rtl/loader_word_packer.sv
// Assembles little-endian 32-bit words from accepted stream bytes.
// word_c/word_complete_c expose the word including the byte being accepted this cycle.
module loader_word_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [WORD_W-1:0] word_c,
  output logic              word_complete_c
);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] word_q, word_d;

  // Insert the incoming byte at lane cnt_q; the counter wraps 3->0 on the last lane.
  always_comb begin
    word_c = word_q;
    word_c[{cnt_q, 3'b000} +: BYTE_W] = byte_in;
    word_complete_c = byte_valid && (cnt_q == CNT_W'(BYTES_PER_WORD - 1));
    cnt_d  = cnt_q;
    word_d = word_q;
    if (clear) begin
      cnt_d  = '0;
      word_d = '0;
    end else if (byte_valid) begin
      cnt_d  = cnt_q + CNT_W'(1);
      word_d = word_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Fills IMEM from a length-prefixed, XOR-checksummed byte stream and
// holds the processor in reset until a verified image is in place.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              restart,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam int unsigned IDX_W    = ADDR_W + 1;
  localparam int unsigned CAPACITY = 2 ** ADDR_W;

  state_e            state_q, state_d;
  logic [BYTE_W-1:0] len_lo_q, len_lo_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [BYTE_W-1:0] csum_q, csum_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [WORD_W-1:0] imem_wdata_q, imem_wdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              cpu_hold_q, cpu_hold_d;

  logic              in_ready_c;
  logic              accept_c;
  logic              byte_valid_c;
  logic              clear_c;
  logic [LEN_W-1:0]  len_full_c;
  logic [IDX_W-1:0]  idx_inc_c;
  logic [WORD_W-1:0] word_c;
  logic              word_complete_c;

  assign in_ready_c   = !rst && (state_q != DONE) && (state_q != ERROR);
  assign accept_c     = in_valid && in_ready_c;
  assign byte_valid_c = accept_c && (state_q == DATA);
  assign clear_c      = restart && ((state_q == DONE) || (state_q == ERROR));
  assign len_full_c   = {in_data, len_lo_q};
  assign idx_inc_c    = idx_q + IDX_W'(1);

  loader_word_packer u_packer (
    .clk             (clk),
    .rst             (rst),
    .clear           (clear_c),
    .byte_valid      (byte_valid_c),
    .byte_in         (in_data),
    .word_c          (word_c),
    .word_complete_c (word_complete_c)
  );

  always_comb begin
    state_d      = state_q;
    len_lo_d     = len_lo_q;
    len_d        = len_q;
    idx_d        = idx_q;
    csum_d       = csum_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    done_d       = done_q;
    err_d        = err_q;
    cpu_hold_d   = cpu_hold_q;
    case (state_q)
      LEN_LO: begin
        if (accept_c) begin
          len_lo_d = in_data;
          state_d  = LEN_HI;
        end
      end
      LEN_HI: begin
        if (accept_c) begin
          len_d = len_full_c;
          if (32'(len_full_c) > CAPACITY) begin
            state_d = ERROR;
            err_d   = 1'b1;
          end else if (len_full_c == '0) begin
            state_d = CSUM;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (byte_valid_c) begin
          csum_d = csum_q ^ in_data;
          // Word i is written the cycle after its 4th byte is accepted.
          if (word_complete_c) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = idx_q[ADDR_W-1:0];
            imem_wdata_d = word_c;
            idx_d        = idx_inc_c;
            if (LEN_W'(idx_inc_c) == len_q) state_d = CSUM;
          end
        end
      end
      CSUM: begin
        if (accept_c) begin
          if (in_data == csum_q) begin
            state_d    = DONE;
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
          end else begin
            state_d = ERROR;
            err_d   = 1'b1;
          end
        end
      end
      DONE, ERROR: begin
        if (clear_c) begin
          state_d    = LEN_LO;
          len_lo_d   = '0;
          len_d      = '0;
          idx_d      = '0;
          csum_d     = '0;
          done_d     = 1'b0;
          err_d      = 1'b0;
          cpu_hold_d = 1'b1;
        end
      end
      default: state_d = LEN_LO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= LEN_LO;
      len_lo_q     <= '0;
      len_q        <= '0;
      idx_q        <= '0;
      csum_q       <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      cpu_hold_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      len_lo_q     <= len_lo_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      csum_q       <= csum_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      done_q       <= done_d;
      err_q        <= err_d;
      cpu_hold_q   <= cpu_hold_d;
    end
  end

  assign in_ready   = in_ready_c;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign done       = done_q;
  assign err        = err_q;
  assign cpu_hold   = cpu_hold_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboarded random bench for imem_loader (ADDR_W=2, capacity 4 words).
module tb_imem_loader;

  localparam int unsigned AW = 2;
  localparam int unsigned CAP = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          restart;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_hold;
  logic          done;
  logic          err;

  int tests = 0;
  int fails = 0;

  logic [AW-1:0] exp_addr_q[$];
  logic [31:0]   exp_data_q[$];
  logic [31:0]   img[$];
  logic [AW-1:0] mon_addr;
  logic [31:0]   mon_data;

  imem_loader #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .restart    (restart),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every write pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (exp_addr_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%08h, expected no write", imem_addr, imem_wdata);
      end else begin
        mon_addr = exp_addr_q.pop_front();
        mon_data = exp_data_q.pop_front();
        check("write_addr", 32'(imem_addr), 32'(mon_addr));
        check("write_data", imem_wdata, mon_data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        tick();
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 20 && !in_ready; i++) tick();
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: got in_ready=0 for 20 cycles, expected 1");
    end
    tick();
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  // Reference: words land at addr 0..n-1 iff n fits; checksum is XOR of data bytes.
  task automatic send_image(input int n, input logic [7:0] cs_flip, input bit gaps);
    logic [7:0] cs;
    logic [7:0] b;
    bit ok;
    cs = 8'h00;
    send_byte(8'(n), gaps);
    send_byte(8'(n >> 8), gaps);
    if (n <= CAP) begin
      for (int i = 0; i < n; i++) begin
        exp_addr_q.push_back(AW'(i));
        exp_data_q.push_back(img[i]);
      end
      for (int i = 0; i < n; i++) begin
        for (int k = 0; k < 4; k++) begin
          b  = 8'(img[i] >> (8 * k));
          cs = cs ^ b;
          send_byte(b, gaps);
        end
      end
      send_byte(cs ^ cs_flip, gaps);
    end
    ok = (n <= CAP) && (cs_flip == 8'h00);
    check("done", 32'(done), 32'(ok));
    check("err", 32'(err), 32'(!ok));
    check("cpu_hold", 32'(cpu_hold), 32'(!ok));
    check("in_ready_end", 32'(in_ready), 32'd0);
    check("pending_writes", 32'(exp_addr_q.size()), 32'd0);
  endtask

  task automatic do_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check("restart_ready", 32'(in_ready), 32'd1);
    check("restart_done", 32'(done), 32'd0);
    check("restart_err", 32'(err), 32'd0);
    check("restart_hold", 32'(cpu_hold), 32'd1);
  endtask

  task automatic fill_img(input int n);
    img.delete();
    for (int i = 0; i < n; i++) img.push_back($urandom);
  endtask

  task automatic check_reset_outputs();
    check("rst_we", 32'(imem_we), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_hold", 32'(cpu_hold), 32'd1);
    check("rst_ready", 32'(in_ready), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w3 [3];
    logic [7:0]  flip;
    int          n;

    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    restart  = 1'b0;
    repeat (3) tick();
    check_reset_outputs();
    rst = 1'b0;
    #1;
    check("ready_after_rst", 32'(in_ready), 32'd1);

    // Single word: 01 00 78 56 34 12 08
    img.delete();
    img.push_back(32'h1234_5678);
    send_image(1, 8'h00, 1'b0);
    check("addr_hold", 32'(imem_addr), 32'd0);
    check("wdata_hold", imem_wdata, 32'h1234_5678);
    in_valid = 1'b1;
    repeat (4) begin
      in_data = 8'($urandom);
      tick();
    end
    in_valid = 1'b0;
    check("done_sticky", 32'(done), 32'd1);

    // Bad checksum 0x09
    do_restart();
    send_image(1, 8'h01, 1'b0);

    // Length boundary
    do_restart();
    send_image(5, 8'h00, 1'b0);
    do_restart();
    fill_img(4);
    send_image(4, 8'h00, 1'b0);

    // Zero length
    do_restart();
    send_image(0, 8'h00, 1'b0);

    // Same 3-word image without and with gaps
    do_restart();
    fill_img(3);
    for (int i = 0; i < 3; i++) w3[i] = img[i];
    send_image(3, 8'h00, 1'b0);
    do_restart();
    img.delete();
    for (int i = 0; i < 3; i++) img.push_back(w3[i]);
    send_image(3, 8'h00, 1'b1);

    // Reset after two data bytes of word 1
    do_restart();
    fill_img(2);
    exp_addr_q.push_back(AW'(0));
    exp_data_q.push_back(img[0]);
    send_byte(8'd2, 1'b0);
    send_byte(8'd0, 1'b0);
    for (int k = 0; k < 4; k++) send_byte(8'(img[0] >> (8 * k)), 1'b0);
    send_byte(8'(img[1]), 1'b0);
    send_byte(8'(img[1] >> 8), 1'b0);
    rst = 1'b1;
    #1;
    check("ready_in_rst", 32'(in_ready), 32'd0);
    tick();
    check_reset_outputs();
    rst = 1'b0;
    repeat (2) tick();
    check("rst_no_write", 32'(exp_addr_q.size()), 32'd0);
    fill_img(2);
    send_image(2, 8'h00, 1'b1);

    // Restart from DONE with a fresh 2-word image
    do_restart();
    fill_img(2);
    send_image(2, 8'h00, 1'b0);

    // Random images
    for (int t = 0; t < 8; t++) begin
      do_restart();
      n = $urandom_range(0, 5);
      flip = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      fill_img(4);
      send_image(n, flip, 1'b1);
    end

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
